// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between I-cache refills and D-cache traffic.
// D-cache wins ties; a starvation counter guarantees the I-cache forward progress.
module mem_port_arbiter #(
  parameter int ADDR       = 32,
  parameter int DATA       = 32,
  parameter int BEATS      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ic_req,
  input  logic [ADDR-1:0] ic_addr,
  output logic            ic_rvalid,
  output logic [DATA-1:0] ic_rdata,
  output logic            ic_done,
  input  logic            dc_req,
  input  logic            dc_we,
  input  logic [ADDR-1:0] dc_addr,
  input  logic [DATA-1:0] dc_wdata,
  output logic            dc_rvalid,
  output logic [DATA-1:0] dc_rdata,
  output logic            dc_done,
  output logic            mem_req,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DATA-1:0] mem_rdata
);

  localparam int BW = $clog2(BEATS);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDATA
  } state_t;

  typedef enum logic {
    OWN_IC,
    OWN_DC
  } owner_t;

  state_t        state;
  owner_t        owner;
  logic [BW-1:0] beat_cnt;
  logic [SW-1:0] starve_cnt;

  logic go;
  logic starved;
  logic grant_ic;
  logic grant_dc;
  logic last_beat;

  // Hold off arbitration while a done pulse is visible so the requester
  // gets a cycle to drop its request.
  always_comb begin
    go        = !ic_done && !dc_done;
    starved   = starve_cnt >= SW'(STARVE_MAX);
    grant_dc  = go && dc_req && (!ic_req || !starved);
    grant_ic  = go && ic_req && !grant_dc;
    last_beat = beat_cnt == BW'(BEATS - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_IC;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ic_rvalid  <= 1'b0;
      ic_rdata   <= '0;
      ic_done    <= 1'b0;
      dc_rvalid  <= 1'b0;
      dc_rdata   <= '0;
      dc_done    <= 1'b0;
    end else begin
      ic_rvalid <= 1'b0;
      dc_rvalid <= 1'b0;
      ic_done   <= 1'b0;
      dc_done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_dc) begin
            owner     <= OWN_DC;
            mem_req   <= 1'b1;
            mem_we    <= dc_we;
            mem_addr  <= dc_addr;
            mem_wdata <= dc_wdata;
            state     <= ISSUE;
            if (!ic_req)
              starve_cnt <= '0;
            else if (!starved)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_ic) begin
            owner      <= OWN_IC;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= ic_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              dc_done <= 1'b1;
              state   <= IDLE;
            end else begin
              beat_cnt <= '0;
              state    <= RDATA;
            end
          end
        end
        RDATA: begin
          if (mem_rvalid) begin
            if (owner == OWN_DC) begin
              dc_rvalid <= 1'b1;
              dc_rdata  <= mem_rdata;
              dc_done   <= last_beat;
            end else begin
              ic_rvalid <= 1'b1;
              ic_rdata  <= mem_rdata;
              ic_done   <= last_beat;
            end
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        ic_rvalid;
  logic [31:0] ic_rdata;
  logic        ic_done;
  logic        dc_req = 1'b0;
  logic        dc_we = 1'b0;
  logic [31:0] dc_addr = '0;
  logic [31:0] dc_wdata = '0;
  logic        dc_rvalid;
  logic [31:0] dc_rdata;
  logic        dc_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_chk = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .ADDR(32), .DATA(32), .BEATS(4), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_rvalid(dc_rvalid),
    .dc_rdata(dc_rdata), .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_ic_rvalid"}, ic_rvalid, 0);
    chk({tag, "_ic_done"}, ic_done, 0);
    chk({tag, "_dc_rvalid"}, dc_rvalid, 0);
    chk({tag, "_dc_done"}, dc_done, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk_quiet(tag);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_ic_rdata"}, ic_rdata, 0);
    chk({tag, "_dc_rdata"}, dc_rdata, 0);
  endtask

  // Wait a bounded number of cycles for mem_req.
  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!mem_req && n < 6) begin
      tick;
      n++;
    end
    chk({tag, "_req_seen"}, mem_req, 1);
  endtask

  // Burst of 4 back-to-back beats for the given owner.
  task automatic burst(input string tag, input logic is_dc,
                       input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + 32'(i);
      tick;
      chk({tag, "_rv"}, is_dc ? dc_rvalid : ic_rvalid, 1);
      chk({tag, "_rd"}, is_dc ? dc_rdata : ic_rdata, base + 32'(i));
      chk({tag, "_other_rv"}, is_dc ? ic_rvalid : dc_rvalid, 0);
      chk({tag, "_done"}, is_dc ? dc_done : ic_done, (i == 3) ? 1 : 0);
    end
    mem_rvalid = 1'b0;
  endtask

  int   pat[7] = '{1, 0, 0, 1, 1, 0, 1};
  int   nb;
  logic exp_ic;

  initial begin
    tick;
    tick;
    chk_reset("reset");
    reset = 1'b0;
    tick;
    chk_quiet("idle");

    // I-cache only burst
    ic_req  = 1'b1;
    ic_addr = 32'h100;
    tick;
    chk("ic_mem_req", mem_req, 1);
    chk("ic_mem_addr", mem_addr, 32'h100);
    chk("ic_mem_we", mem_we, 0);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    chk("ic_accept", mem_req, 0);
    burst("ic", 1'b0, 32'hA0);
    chk("ic_dc_done", dc_done, 0);
    ic_req = 1'b0;
    tick;
    chk_quiet("ic_after");
    chk("ic_rdata_hold", ic_rdata, 32'hA3);

    // D-cache write with stalled acceptance
    dc_req   = 1'b1;
    dc_we    = 1'b1;
    dc_addr  = 32'h200;
    dc_wdata = 32'hDEAD;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("wr_req", mem_req, 1);
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, 32'h200);
      chk("wr_wdata", mem_wdata, 32'hDEAD);
      chk("wr_early_done", dc_done, 0);
      mem_ready = (k == 3);
      tick;
    end
    mem_ready = 1'b0;
    chk("wr_done", dc_done, 1);
    chk("wr_req_drop", mem_req, 0);
    chk("wr_no_rv", dc_rvalid, 0);
    dc_req = 1'b0;
    tick;
    chk_quiet("wr_after");

    // Priority and starvation: DC DC DC IC DC DC DC IC
    ic_req   = 1'b1;
    ic_addr  = 32'h300;
    dc_req   = 1'b1;
    dc_we    = 1'b1;
    dc_addr  = 32'h400;
    dc_wdata = 32'h55;
    for (int g = 0; g < 8; g++) begin
      wait_req("arb");
      exp_ic = (g % 4 == 3);
      chk("arb_we", mem_we, exp_ic ? 0 : 1);
      chk("arb_addr", mem_addr, exp_ic ? 32'h300 : 32'h400);
      mem_ready = 1'b1;
      tick;
      mem_ready = 1'b0;
      if (exp_ic)
        burst("arb_ic", 1'b0, 32'hC0);
      else
        chk("arb_dc_done", dc_done, 1);
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    tick;
    chk_quiet("arb_after");

    // Gapped D-cache read burst
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 32'h500;
    tick;
    chk("gap_req", mem_req, 1);
    chk("gap_we", mem_we, 0);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    nb = 0;
    for (int i = 0; i < 7; i++) begin
      mem_rvalid = (pat[i] != 0);
      mem_rdata  = 32'hB0 + 32'(i);
      tick;
      if (pat[i] != 0) nb++;
      chk("gap_rv", dc_rvalid, pat[i]);
      chk("gap_ic_rv", ic_rvalid, 0);
      chk("gap_done", dc_done, (pat[i] != 0 && nb == 4) ? 1 : 0);
      if (pat[i] != 0) chk("gap_rd", dc_rdata, 32'hB0 + 32'(i));
    end
    mem_rvalid = 1'b0;
    dc_req     = 1'b0;
    tick;
    chk_quiet("gap_after");
    chk("gap_rdata_hold", dc_rdata, 32'hB6);

    // Reset after two beats of an I-cache burst
    ic_req  = 1'b1;
    ic_addr = 32'h600;
    tick;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hE0 + 32'(i);
      tick;
      chk("rst_pre_rv", ic_rvalid, 1);
    end
    mem_rvalid = 1'b0;
    ic_req     = 1'b0;
    reset      = 1'b1;
    tick;
    chk_reset("midrst");
    reset = 1'b0;
    tick;
    chk_quiet("midrst_idle");
    ic_req = 1'b1;
    tick;
    chk("rst_fresh_req", mem_req, 1);
    chk("rst_fresh_addr", mem_addr, 32'h600);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    burst("rst_fresh", 1'b0, 32'hF0);
    ic_req = 1'b0;
    tick;

    // Stray beats in IDLE and ISSUE
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77;
    tick;
    chk_quiet("stray_idle");
    mem_rvalid = 1'b0;
    dc_req     = 1'b1;
    dc_we      = 1'b0;
    dc_addr    = 32'h700;
    tick;
    chk("stray_req", mem_req, 1);
    mem_rvalid = 1'b1;
    tick;
    chk("stray_issue_rv", dc_rvalid, 0);
    chk("stray_issue_req", mem_req, 1);
    mem_rvalid = 1'b0;
    mem_ready  = 1'b1;
    tick;
    mem_ready = 1'b0;
    burst("stray_burst", 1'b1, 32'hD0);
    dc_req = 1'b0;
    tick;
    chk_quiet("end");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between I-cache refill (read bursts) and D-cache traffic (read bursts, single-beat writes).
- Sits below the pseudo/real I-cache and D-cache models, above the memory model.
- One transaction outstanding at a time.
- D-cache has priority, with a starvation limit that guarantees I-cache forward progress.

Parameters:
- ADDR, 32, address width.
- DATA, 32, data/beat width.
- BEATS, 4, read-burst length in beats (power of 2, ≥2).
- STARVE_MAX, 3, max consecutive D-cache grants while I-cache waits (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ic_req  in  1  I-cache read-burst request; level, held until ic_done.
- ic_addr  in  ADDR  burst base address; stable while ic_req.
- ic_rvalid  out  1  read beat valid to I-cache.
- ic_rdata  out  DATA  read beat data.
- ic_done  out  1  one-cycle pulse with last beat.
- dc_req  in  1  D-cache request; level, held until dc_done.
- dc_we  in  1  1 = single-beat write, 0 = read burst.
- dc_addr  in  ADDR  address.
- dc_wdata  in  DATA  write data.
- dc_rvalid  out  1  read beat valid to D-cache.
- dc_rdata  out  DATA  read beat data.
- dc_done  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR  address.
- mem_wdata  out  DATA  write data.
- mem_ready  in  1  memory accepts request this cycle (when mem_req=1).
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  DATA  read beat data.

Behaviour:
- Reset: state=IDLE, owner=IC, beat_cnt=0, starve_cnt=0. All outputs 0: mem_*, *_rvalid, *_rdata, *_done.
- FSM states: IDLE, ISSUE, RDATA.
- IDLE:
  - Arbitrate on the current-cycle ic_req/dc_req.
  - Only ic_req → grant IC.
  - Only dc_req → grant DC.
  - Both → grant DC if starve_cnt < STARVE_MAX, else grant IC.
  - On grant: register owner, addr, we (IC forces we=0), wdata; go to ISSUE.
  - Neither → stay.
  - Latency: request seen at cycle t → mem_req=1 at t+1.
- starve_cnt updates at each grant:
  - DC granted while ic_req=1 → +1 (saturates at STARVE_MAX).
  - IC granted, or ic_req=0 at grant → 0.
- ISSUE:
  - mem_req=1; mem_addr/mem_we/mem_wdata come from registered values and stay stable until accepted.
  - mem_req && mem_ready, we=1 → mem_req=0, dc_done=1 next cycle, go to IDLE.
  - mem_req && mem_ready, we=0 → mem_req=0, beat_cnt=0, go to RDATA.
  - Beats arriving in ISSUE are ignored; memory must not return data before acceptance.
- RDATA:
  - Each mem_rvalid is forwarded registered (1-cycle latency) to the owner: owner_rvalid=1, owner_rdata=mem_rdata. Non-owner rvalid stays 0.
  - beat_cnt increments per beat. On beat BEATS-1: owner_done=1 in the same cycle as the last rvalid output; beat_cnt→0; go to IDLE.
  - Gaps between beats (mem_rvalid=0) are allowed; no timeout.
- The done cycle returns to IDLE. Arbitration in IDLE happens the cycle after done is visible, so the requester can drop req. Back-to-back grants are therefore ≥1 idle cycle apart.
- *_rdata holds its last value when rvalid=0 (not cleared).
- mem_rvalid in IDLE or ISSUE is ignored (no output, no count).
- Reset asserted mid-transaction: return to reset state next cycle. The in-flight burst is abandoned and no done is issued. Caches and memory are reset concurrently.
- Requester dropping req mid-transaction is illegal; the arbiter completes the transaction regardless.
- beat_cnt width = clog2(BEATS); starve_cnt width = clog2(STARVE_MAX+1).

Test Plan:
- IC only: ic_req, addr 0x100; mem_ready in the first ISSUE cycle; 4 beats 0xA0..0xA3 → mem_req one cycle after ic_req; ic_rvalid ×4 with those data; ic_done with 0xA3; dc_* stay 0.
- DC write: dc_req, we=1, addr 0x200, wdata 0xDEAD; mem_ready held low 3 cycles → mem_addr/mem_wdata stable for 4 cycles; dc_done one cycle after acceptance; no rvalid.
- Priority + starvation (STARVE_MAX=3): ic_req and dc_req held continuously, each DC op a write → grant order DC, DC, DC, IC, DC…; starve_cnt resets after the IC grant.
- Gapped burst: DC read with mem_rvalid pattern 1,0,0,1,1,0,1 → dc_rvalid mirrors it delayed by 1 cycle; dc_done exactly with the 4th beat.
- Reset mid-burst: reset after beat 2 of an IC read → next cycle all outputs 0, state IDLE, no ic_done; a fresh ic_req then completes normally.
- Stray data: mem_rvalid pulsed in IDLE and in ISSUE → no *_rvalid, beat count unaffected (the following burst still needs 4 beats).
